// File: rtl/seq_event_monitor.sv
// Counts rising edges of the 11011 detector match: saturating total, fixed-window counts, burst flag, stretched LED.
// Latency: 1 edge from det_in sample to visible count; window result one edge after the last window cycle.
module seq_event_monitor #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 32,
    parameter int THRESH  = 3,
    parameter int STRETCH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             det_in,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] win_cnt,
    output logic             win_valid,
    output logic             burst,
    output logic             led
);

    localparam int WC_W = $clog2(WIN_LEN);
    localparam int SC_W = $clog2(STRETCH + 1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(STRETCH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic             det_q;
    logic             det_d;
    logic             evt;
    logic             state;
    logic [WC_W-1:0]  wcyc;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] win_nxt;
    logic [SC_W-1:0]  scnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    // A held-high match counts once: only the rising edge is an event, and only while enabled.
    assign evt     = det_q & ~det_d & en;
    assign win_nxt = sat_inc(acc, evt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_q <= 1'b0;
            det_d <= 1'b0;
            state <= IDLE;
        end else begin
            det_q <= det_in;
            det_d <= det_q;
            state <= en ? RUN : IDLE;
        end
    end

    // Outside RUN the window state sits at zero, so entering RUN starts a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            wcyc      <= '0;
            win_cnt   <= '0;
            burst     <= 1'b0;
            win_valid <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            wcyc      <= '0;
            win_cnt   <= '0;
            burst     <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (state == RUN && en) begin
                if (wcyc == WC_LAST) begin
                    win_cnt   <= win_nxt;
                    burst     <= (win_nxt >= THR);
                    win_valid <= 1'b1;
                    acc       <= '0;
                    wcyc      <= '0;
                end else begin
                    acc  <= win_nxt;
                    wcyc <= wcyc + WC_W'(1);
                end
            end else begin
                acc  <= '0;
                wcyc <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt <= '0;
            scnt      <= '0;
            led       <= 1'b0;
        end else if (clr) begin
            total_cnt <= '0;
            scnt      <= '0;
            led       <= 1'b0;
        end else begin
            total_cnt <= sat_inc(total_cnt, evt);
            if (evt) begin
                scnt <= SC_LOAD;
                led  <= 1'b1;
            end else if (scnt != '0) begin
                scnt <= scnt - SC_W'(1);
                led  <= (scnt != SC_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_seq_event_monitor.sv
// Bench for seq_event_monitor: window results checked through an expected-window queue, counts and flags checked inline.
module tb_seq_event_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       det_in;
    logic [7:0] total_cnt;
    logic [7:0] win_cnt;
    logic       win_valid;
    logic       burst;
    logic       led;
    logic [2:0] total3;
    logic [2:0] win3;
    logic       wv3;
    logic       burst3;
    logic       led3;

    seq_event_monitor dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .det_in(det_in),
        .total_cnt(total_cnt), .win_cnt(win_cnt), .win_valid(win_valid),
        .burst(burst), .led(led)
    );

    seq_event_monitor #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .det_in(det_in),
        .total_cnt(total3), .win_cnt(win3), .win_valid(wv3),
        .burst(burst3), .led(led3)
    );

    typedef struct {
        logic [7:0] cnt;
        logic       b;
        int         at;
    } win_t;

    win_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    logic sb_on  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (sb_on && win_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_win_valid", 32'(win_cnt), 32'hFFFF_FFFF);
            end else begin
                win_t w;
                w = sb_q.pop_front();
                chk("win_cnt", 32'(win_cnt), 32'(w.cnt));
                chk("burst", 32'(burst), 32'(w.b));
                chk("win_valid_cycle", cyc, w.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse();
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        tick();
    endtask

    task automatic push_win(input logic [7:0] c, input logic b, input int at);
        win_t w;
        w.cnt = c;
        w.b   = b;
        w.at  = at;
        sb_q.push_back(w);
    endtask

    // Returns the edge number at which RUN is entered, with counts cleared beforehand.
    task automatic start_run(output int e);
        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        en = 1'b1;
        tick();
        e = cyc;
    endtask

    initial begin
        int   e;
        int   e2;
        int   led_cycles;
        logic [4:0] sr;
        logic       bits [12];

        rst_n  = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        det_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_total", 32'(total_cnt), 0);
        chk("rst_win_cnt", 32'(win_cnt), 0);
        chk("rst_win_valid", 32'(win_valid), 0);
        chk("rst_burst", 32'(burst), 0);
        chk("rst_led", 32'(led), 0);
        rst_n = 1'b1;
        tick();

        // Detector output for the bit stream: high for the whole bit that completes 11011.
        bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        sr = '0;
        led_cycles = 0;
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sr = {sr[3:0], bits[i]};
            det_in = (sr == 5'b11011);
            repeat (5) begin
                tick();
                if (led) led_cycles++;
            end
            if (i == 5) chk("stream_hold_once", 32'(total_cnt), 1);
        end
        det_in = 1'b0;
        repeat (12) begin
            tick();
            if (led) led_cycles++;
        end
        chk("stream_total", 32'(total_cnt), 2);
        chk("stream_led_cycles", led_cycles, 16);

        // Two windows: 4 events then 1 event.
        start_run(e);
        sb_on = 1'b1;
        push_win(8'd4, 1'b1, e + 32);
        push_win(8'd1, 1'b0, e + 64);
        repeat (4) pulse();
        chk("win_total4", 32'(total_cnt), 4);
        wait_until(e + 40);
        pulse();
        wait_until(e + 66);
        // Abandon the third window after two events.
        repeat (2) pulse();
        en = 1'b0;
        repeat (3) tick();
        chk("abort_win_cnt_held", 32'(win_cnt), 1);
        chk("abort_burst_held", 32'(burst), 0);
        pulse();
        tick();
        chk("en_low_ignored", 32'(total_cnt), 7);
        wait_until(e + 100);
        en = 1'b1;
        tick();
        e2 = cyc;
        push_win(8'd1, 1'b0, e2 + 32);
        pulse();
        wait_until(e2 + 34);
        chk("reraise_drained", sb_q.size(), 0);

        // Saturation: 10 events in one window on both instances.
        start_run(e);
        push_win(8'd10, 1'b1, e + 32);
        repeat (10) pulse();
        chk("sat_total8", 32'(total_cnt), 10);
        chk("sat_total3", 32'(total3), 7);
        wait_until(e + 32);
        chk("sat_win3_valid", 32'(wv3), 1);
        chk("sat_win3", 32'(win3), 7);
        chk("sat_burst3", 32'(burst3), 1);
        chk("sat_led3", 32'(led3), 0);
        en = 1'b0;
        repeat (3) tick();

        // clr coinciding with an event and a window close, with led lit.
        en = 1'b1;
        tick();
        e = cyc;
        wait_until(e + 26);
        pulse();
        chk("pre_clr_led", 32'(led), 1);
        wait_until(e + 30);
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_total", 32'(total_cnt), 0);
        chk("clr_win_cnt", 32'(win_cnt), 0);
        chk("clr_burst", 32'(burst), 0);
        chk("clr_led", 32'(led), 0);
        chk("clr_win_valid", 32'(win_valid), 0);
        tick();
        chk("clr_event_dropped", 32'(total_cnt), 0);
        en = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of a run.
        start_run(e);
        repeat (5) pulse();
        chk("pre_rst_total", 32'(total_cnt), 5);
        chk("pre_rst_led", 32'(led), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_total", 32'(total_cnt), 0);
        chk("async_rst_win_cnt", 32'(win_cnt), 0);
        chk("async_rst_win_valid", 32'(win_valid), 0);
        chk("async_rst_burst", 32'(burst), 0);
        chk("async_rst_led", 32'(led), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        pulse();
        chk("post_rst_total", 32'(total_cnt), 1);
        en = 1'b0;
        repeat (3) tick();
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
